// File: rtl/regport_pkg.sv
// Shared definitions for the register-file read-port arbiter.
//   N_REQ  : number of requesters sharing the port (fixed, 2-bit mux select)
//   ADDR_W : register address width
//   DATA_W : read data width
//   state_t: arbiter state (IDLE: nobody owns the port, OWN: owner may read)
//   onehot_sel(): index to one-hot requester vector
package regport_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regport_arbiter_if.sv
// Bundle of the requester-side and register-file-side signals of the read
// port arbiter.
//   req      : per-requester read request (level, held until served)
//   addr     : packed requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt      : one-hot, read issued for requester i this cycle
//   rf_sel   : select for the external 32-bit 4:1 data mux (current owner)
//   rf_addr  : address driven to the register file
//   rf_rdata : combinational read data returned by the register file
//   rdata    : registered read data
//   rvalid   : one-hot pulse, rdata belongs to requester i
//   busy     : arbiter currently has an owner
// Modports: slave = arbiter side, master = requesters + register file side.
interface regport_arbiter_if;
  import regport_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [SEL_W-1:0]        rf_sel;
  logic [ADDR_W-1:0]       rf_addr;
  logic [DATA_W-1:0]       rf_rdata;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;
  logic                    busy;

  modport slave (
    input  req, addr, rf_rdata,
    output gnt, rf_sel, rf_addr, rdata, rvalid, busy
  );

  modport master (
    output req, addr, rf_rdata,
    input  gnt, rf_sel, rf_addr, rdata, rvalid, busy
  );

endinterface

// File: rtl/regport_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req : request vector
//   ptr : highest-priority index for this pick
//   any : at least one request present
//   idx : first requesting index scanning ptr, ptr+1, ... (mod 4)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand [4];
  logic [3:0] hit;

  // cand[k] is the k-th index in scan order; 2-bit add wraps mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = ptr + 2'(gi);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Scan from the back so the earliest hit in scan order wins.
  always_comb begin
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/regport_arbiter.sv
// Round-robin arbiter sharing one register-file read port among four
// requesters. Drives the select of the external 32-bit 4:1 data mux and the
// owner's register address, registers the returned data and pulses a
// per-requester valid one cycle after each issued read. Ownership lasts at
// most MAX_HOLD consecutive reads, then passes on without an idle cycle.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : regport_arbiter_if slave modport (see interface header)
// Parameter MAX_HOLD (1..15): max consecutive reads per ownership.
module regport_arbiter
  import regport_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  regport_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t            state_reg;
  logic [SEL_W-1:0]  owner_reg;
  logic [SEL_W-1:0]  rr_ptr_reg;
  logic [3:0]        hold_cnt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [N_REQ-1:0]  rvalid_reg;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic              own_req;
  logic              issue;
  logic              last_read;
  logic              release_own;
  logic [SEL_W-1:0]  pick_ptr;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  assign own_req     = bus.req[owner_reg];
  assign issue       = (state_reg == OWN) && own_req;
  assign last_read   = issue && ((hold_cnt_reg + 4'd1) == HOLD_LIM);
  assign release_own = (state_reg == OWN) && (!own_req || last_read);

  // While owning, the picker only matters on a release edge, where the scan
  // must already start after the owner so the handoff needs no extra cycle.
  // A lone requester wraps back to itself and re-wins immediately.
  assign pick_ptr = (state_reg == OWN) ? owner_reg + 2'd1 : rr_ptr_reg;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign bus.gnt     = issue ? onehot_sel(owner_reg) : '0;
  assign bus.rf_sel  = owner_reg;
  assign bus.rf_addr = addr_arr[owner_reg];
  assign bus.rdata   = rdata_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.busy    = (state_reg == OWN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= '0;
    end else begin
      rvalid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            state_reg    <= OWN;
            owner_reg    <= pick_idx;
            hold_cnt_reg <= '0;
          end
        end
        OWN: begin
          if (issue) begin
            rdata_reg    <= bus.rf_rdata;
            rvalid_reg   <= onehot_sel(owner_reg);
            hold_cnt_reg <= hold_cnt_reg + 4'd1;
          end
          if (release_own) begin
            rr_ptr_reg   <= owner_reg + 2'd1;
            hold_cnt_reg <= '0;
            if (pick_any) begin
              owner_reg <= pick_idx;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regport_arbiter.sv
// Self-checking bench for regport_arbiter. Three instances (MAX_HOLD 4, 1, 2)
// share clock, reset, req and addr; each scenario checks the instance whose
// hold limit it targets. Grants are checked per cycle against hand-derived
// tables; each expected grant pushes {cycle, requester, data} to a scoreboard
// that is popped when the matching rvalid is due one cycle later.
module tb_regport_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] addr;
  logic [31:0] mem [32];

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks;
  int n_pass;

  regport_arbiter_if if4 ();
  regport_arbiter_if if1 ();
  regport_arbiter_if if2 ();

  assign if4.req = req;
  assign if4.addr = addr;
  assign if4.rf_rdata = mem[if4.rf_addr];
  assign if1.req = req;
  assign if1.addr = addr;
  assign if1.rf_rdata = mem[if1.rf_addr];
  assign if2.req = req;
  assign if2.addr = addr;
  assign if2.rf_rdata = mem[if2.rf_addr];

  regport_arbiter #(.MAX_HOLD(4)) u_h4 (.clk(clk), .reset(reset), .bus(if4));
  regport_arbiter #(.MAX_HOLD(1)) u_h1 (.clk(clk), .reset(reset), .bus(if1));
  regport_arbiter #(.MAX_HOLD(2)) u_h2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int oh2idx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int idx);
    logic [4:0] a;
    a = addr[idx*5 +: 5];
    return mem[a];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    addr = {5'd3, 5'd12, 5'd20, 5'd7};
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (if4.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", if4.busy); else n_pass++;
    n_checks++; if (if4.gnt !== 4'b0000) $display("FAIL reset gnt: got %b want 0000", if4.gnt); else n_pass++;
    n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL reset rvalid: got %b want 0000", if4.rvalid); else n_pass++;
    n_checks++; if (if4.rdata !== 32'h0) $display("FAIL reset rdata: got %h want 00000000", if4.rdata); else n_pass++;
    n_checks++; if (if4.rf_sel !== 2'd0) $display("FAIL reset rf_sel: got %0d want 0", if4.rf_sel); else n_pass++;
    n_checks++; if (if4.rf_addr !== 5'd7) $display("FAIL reset rf_addr: got %0d want 7", if4.rf_addr); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] r [4];
    logic [3:0] eg [4];
    logic [3:0] eb;
    sb_item_t   e;
    r  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    eb = 4'b0110; // busy per cycle, bit c
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; req = r[c];
      @(negedge clk);
      n_checks++; if (if4.gnt !== eg[c]) $display("FAIL single gnt c%0d: got %b want %b", c, if4.gnt, eg[c]); else n_pass++;
      n_checks++; if (if4.busy !== eb[c]) $display("FAIL single busy c%0d: got %b want %b", c, if4.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if4.rvalid !== (4'b0001 << e.idx) || if4.rdata !== e.data)
          $display("FAIL single rvalid c%0d: got %b/%h want %b/%h", c, if4.rvalid, if4.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL single rvalid c%0d: got %b want 0000", c, if4.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
    end
    n_checks++; if (if4.rdata !== 32'hDEADBEEF) $display("FAIL single rdata_hold: got %h want deadbeef", if4.rdata); else n_pass++;
  endtask

  task automatic test_hold_limit();
    logic [3:0] r [9];
    logic [3:0] eg [9];
    logic [8:0] eb;
    sb_item_t   e;
    r  = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    eb = 9'b0_1111_1110;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1; req = r[c];
      @(negedge clk);
      n_checks++; if (if4.gnt !== eg[c]) $display("FAIL hold gnt c%0d: got %b want %b", c, if4.gnt, eg[c]); else n_pass++;
      n_checks++; if (if4.busy !== eb[c]) $display("FAIL hold busy c%0d: got %b want %b", c, if4.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if4.rvalid !== (4'b0001 << e.idx) || if4.rdata !== e.data)
          $display("FAIL hold rvalid c%0d: got %b/%h want %b/%h", c, if4.rvalid, if4.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL hold rvalid c%0d: got %b want 0000", c, if4.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
    end
  endtask

  task automatic test_full_rotation();
    logic [3:0] r [8];
    logic [3:0] eg [8];
    logic [7:0] eb;
    sb_item_t   e;
    r  = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    eb = 8'b0111_1110;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; req = r[c];
      @(negedge clk);
      n_checks++; if (if1.gnt !== eg[c]) $display("FAIL rotate gnt c%0d: got %b want %b", c, if1.gnt, eg[c]); else n_pass++;
      n_checks++; if (if1.busy !== eb[c]) $display("FAIL rotate busy c%0d: got %b want %b", c, if1.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if1.rvalid !== (4'b0001 << e.idx) || if1.rdata !== e.data)
          $display("FAIL rotate rvalid c%0d: got %b/%h want %b/%h", c, if1.rvalid, if1.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if1.rvalid !== 4'b0000) $display("FAIL rotate rvalid c%0d: got %b want 0000", c, if1.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
    end
  endtask

  task automatic test_early_release();
    logic [3:0] r [7];
    logic [3:0] eg [7];
    logic [6:0] eb;
    sb_item_t   e;
    int         cnt2;
    r  = '{4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    eb = 7'b011_1110;
    cnt2 = 0;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1; req = r[c];
      @(negedge clk);
      if (if4.rvalid[2] === 1'b1) cnt2++;
      n_checks++; if (if4.gnt !== eg[c]) $display("FAIL early gnt c%0d: got %b want %b", c, if4.gnt, eg[c]); else n_pass++;
      n_checks++; if (if4.busy !== eb[c]) $display("FAIL early busy c%0d: got %b want %b", c, if4.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if4.rvalid !== (4'b0001 << e.idx) || if4.rdata !== e.data)
          $display("FAIL early rvalid c%0d: got %b/%h want %b/%h", c, if4.rvalid, if4.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL early rvalid c%0d: got %b want 0000", c, if4.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
    end
    n_checks++; if (cnt2 != 2) $display("FAIL early rvalid2_count: got %0d want 2", cnt2); else n_pass++;
  endtask

  task automatic test_lone_rewin();
    logic [3:0] r [8];
    logic [3:0] eg [8];
    logic [7:0] eb;
    sb_item_t   e;
    r  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    eb = 8'b0111_1110;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; req = r[c];
      @(negedge clk);
      n_checks++; if (if2.gnt !== eg[c]) $display("FAIL rewin gnt c%0d: got %b want %b", c, if2.gnt, eg[c]); else n_pass++;
      n_checks++; if (if2.busy !== eb[c]) $display("FAIL rewin busy c%0d: got %b want %b", c, if2.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if2.rvalid !== (4'b0001 << e.idx) || if2.rdata !== e.data)
          $display("FAIL rewin rvalid c%0d: got %b/%h want %b/%h", c, if2.rvalid, if2.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if2.rvalid !== 4'b0000) $display("FAIL rewin rvalid c%0d: got %b want 0000", c, if2.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
    end
  endtask

  task automatic test_mid_read_reset();
    logic [3:0] r [8];
    logic [3:0] eg [8];
    logic [7:0] eb;
    sb_item_t   e;
    r  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    eb = 8'b0110_1110;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; reset = 1'b0; req = r[c];
      @(negedge clk);
      n_checks++; if (if4.gnt !== eg[c]) $display("FAIL midrst gnt c%0d: got %b want %b", c, if4.gnt, eg[c]); else n_pass++;
      n_checks++; if (if4.busy !== eb[c]) $display("FAIL midrst busy c%0d: got %b want %b", c, if4.busy, eb[c]); else n_pass++;
      if (sb_q.size() > 0 && sb_q[0].cyc == c - 1) begin
        e = sb_q.pop_front();
        n_checks++;
        if (if4.rvalid !== (4'b0001 << e.idx) || if4.rdata !== e.data)
          $display("FAIL midrst rvalid c%0d: got %b/%h want %b/%h", c, if4.rvalid, if4.rdata, 4'b0001 << e.idx, e.data);
        else n_pass++;
      end else begin
        n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL midrst rvalid c%0d: got %b want 0000", c, if4.rvalid); else n_pass++;
      end
      if (eg[c] != 4'b0000) sb_q.push_back('{cyc: c, idx: oh2idx(eg[c]), data: exp_data(oh2idx(eg[c]))});
      if (c == 3) begin
        // Reset lands while requester 0 is being granted; its read is lost.
        reset = 1'b1;
        #1;
        sb_q.delete();
        n_checks++; if (if4.gnt !== 4'b0000) $display("FAIL midrst reset_gnt: got %b want 0000", if4.gnt); else n_pass++;
        n_checks++; if (if4.busy !== 1'b0) $display("FAIL midrst reset_busy: got %b want 0", if4.busy); else n_pass++;
        n_checks++; if (if4.rvalid !== 4'b0000) $display("FAIL midrst reset_rvalid: got %b want 0000", if4.rvalid); else n_pass++;
        n_checks++; if (if4.rdata !== 32'h0) $display("FAIL midrst reset_rdata: got %h want 00000000", if4.rdata); else n_pass++;
        n_checks++; if (if4.rf_sel !== 2'd0) $display("FAIL midrst reset_rf_sel: got %0d want 0", if4.rf_sel); else n_pass++;
        n_checks++; if (if4.rf_addr !== 5'd7) $display("FAIL midrst reset_rf_addr: got %0d want 7", if4.rf_addr); else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    addr     = {5'd3, 5'd12, 5'd20, 5'd7};
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i * 32'h0011_2233;
    mem[7] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_single();
    test_hold_limit();
    test_full_rotation();
    test_early_release();
    test_lone_rewin();
    test_mid_read_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
